mux_select_sequencer: RTL and testbench

Upstream driver for the 8:1 multiplexer stage. Accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs. Steps the 3-bit select through all eight positions, so the mux output presents the word one bit at a time. Flags each valid select beat and the final beat for the downstream consumer.

---
 rtl/mux_seq_pkg.sv | 21 ++
 rtl/mux_hold_counter.sv | 39 +++
 rtl/mux_select_sequencer.sv | 101 ++++++++++
 tb/tb_mux_select_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux select sequencer: widths, FSM states,
// and the start/final select index for either scan order.
package mux_seq_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
        return msb_first ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [SEL_W-1:0] sel_final(input bit msb_first);
        return msb_first ? 3'd0 : 3'd7;
    endfunction

endpackage

// File: rtl/mux_hold_counter.sv
// Down-counter that times how long each select value is held.
// A load takes priority; otherwise it counts down while enabled and stops at zero.
module mux_hold_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] reload_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: defaulting every always_comb output first is what keeps this a
    // mux instead of an inferred latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = reload_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_select_sequencer.sv
// Holds an accepted word on the 8:1 mux data inputs and steps the select
// through all eight positions, HOLD_CYCLES clocks per position.
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter bit          MSB_FIRST   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              abort,
    output logic [DATA_W-1:0] mux_i,
    output logic [SEL_W-1:0]  mux_s,
    output logic              sel_valid,
    output logic              sel_last,
    output logic              busy
);

    localparam logic [SEL_W-1:0] SEL_FIRST   = sel_first(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST    = sel_final(MSB_FIRST);
    localparam logic [7:0]       HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [SEL_W-1:0]    sel_q, sel_d;

    logic                cnt_load;
    logic [7:0]          cnt_reload;
    logic                cnt_en;
    logic                cnt_zero;

    logic                run;
    logic                final_beat;
    logic                accept;

    mux_hold_counter #(.W(8)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (cnt_load),
        .reload_i (cnt_reload),
        .en_i     (cnt_en),
        .zero_o   (cnt_zero)
    );

    assign run        = (state_q == RUN);
    assign final_beat = run && (sel_q == SEL_LAST) && cnt_zero;
    // Ready depends on registered state only, so it can never loop back through load_valid.
    assign load_ready = !run || final_beat;
    assign accept     = load_valid && load_ready && !(run && abort);

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        sel_d      = sel_q;
        cnt_load   = 1'b0;
        cnt_reload = HOLD_RELOAD;
        cnt_en     = 1'b0;

        if (run && abort) begin
            state_d    = IDLE;
            sel_d      = '0;
            cnt_load   = 1'b1;
            cnt_reload = '0;
        end else if (accept) begin
            state_d  = RUN;
            word_d   = load_data;
            sel_d    = SEL_FIRST;
            cnt_load = 1'b1;
        end else if (final_beat) begin
            // Word complete: select and data stay where they ended.
            state_d = IDLE;
        end else if (run && cnt_zero) begin
            sel_d    = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
            cnt_load = 1'b1;
        end else if (run) begin
            cnt_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
        end
    end

    assign mux_i     = word_q;
    assign mux_s     = sel_q;
    assign sel_valid = run;
    assign busy      = run;
    assign sel_last  = run && (sel_q == SEL_LAST);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: two instances (HOLD=1 LSB-first, HOLD=3
// MSB-first) share stimulus and are compared every cycle to a beat-count model.
module tb_mux_select_sequencer;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       load_valid = 1'b0;
    logic       abort      = 1'b0;
    logic [7:0] load_data  = 8'h00;
    logic       chk_en     = 1'b0;

    logic [7:0] a_mux_i, b_mux_i;
    logic [2:0] a_mux_s, b_mux_s;
    logic       a_sv, b_sv, a_sl, b_sl, a_busy, b_busy, a_rdy, b_rdy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_select_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(a_rdy), .abort(abort), .mux_i(a_mux_i), .mux_s(a_mux_s),
        .sel_valid(a_sv), .sel_last(a_sl), .busy(a_busy)
    );

    mux_select_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(b_rdy), .abort(abort), .mux_i(b_mux_i), .mux_s(b_mux_s),
        .sel_valid(b_sv), .sel_last(b_sl), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a word is 8*H beats ----------------
    logic       m_act  [2];
    logic [7:0] m_word [2];
    int         m_beat [2];
    logic [2:0] m_sret [2];

    function automatic int hold(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit msb(input int d);
        return d == 1;
    endfunction

    function automatic int last_beat(input int d);
        return 8 * hold(d) - 1;
    endfunction

    function automatic logic exp_ready(input int d);
        return !m_act[d] || (m_beat[d] == last_beat(d));
    endfunction

    function automatic logic [2:0] exp_s(input int d);
        int idx;
        if (!m_act[d]) return m_sret[d];
        idx = m_beat[d] / hold(d);
        return msb(d) ? 3'(7 - idx) : 3'(idx);
    endfunction

    function automatic logic exp_last(input int d);
        return m_act[d] && (m_beat[d] / hold(d) == 7);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]  <= 1'b0;
                m_word[d] <= 8'h00;
                m_beat[d] <= 0;
                m_sret[d] <= 3'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_act[d] && abort) begin
                    m_act[d]  <= 1'b0;
                    m_sret[d] <= 3'd0;
                end else if (load_valid && exp_ready(d)) begin
                    m_word[d] <= load_data;
                    m_act[d]  <= 1'b1;
                    m_beat[d] <= 0;
                end else if (m_act[d]) begin
                    if (m_beat[d] == last_beat(d)) begin
                        m_act[d]  <= 1'b0;
                        m_sret[d] <= msb(d) ? 3'd0 : 3'd7;
                    end else begin
                        m_beat[d] <= m_beat[d] + 1;
                    end
                end
            end
        end
    end

    task automatic cmp_dut(input int d, input logic [7:0] mi, input logic [2:0] ms,
                           input logic sv, input logic sl, input logic bz, input logic rdy);
        check($sformatf("d%0d mux_i", d),      32'(mi),  32'(m_word[d]));
        check($sformatf("d%0d mux_s", d),      32'(ms),  32'(exp_s(d)));
        check($sformatf("d%0d sel_valid", d),  32'(sv),  32'(m_act[d]));
        check($sformatf("d%0d sel_last", d),   32'(sl),  32'(exp_last(d)));
        check($sformatf("d%0d busy", d),       32'(bz),  32'(m_act[d]));
        check($sformatf("d%0d load_ready", d), 32'(rdy), 32'(exp_ready(d)));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, a_mux_i, a_mux_s, a_sv, a_sl, a_busy, a_rdy);
            cmp_dut(1, b_mux_i, b_mux_s, b_sv, b_sl, b_busy, b_rdy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic offer_once(input logic [7:0] w);
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data  = w;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!a_busy && !b_busy) done = 1'b1;
        end
        check("wait_idle", 32'(done), 32'd1);
    endtask

    task automatic wait_sel_a(input logic [2:0] s, output bit found);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (a_sv && a_mux_s == s) found = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] y;
        int         sv_cnt;
        int         sl_cnt;
        bit         found;

        // reset
        #2 rst_n = 1'b0;
        #1;
        check("reset a_ready", 32'(a_rdy), 32'd1);
        check("reset a_mux_s", 32'(a_mux_s), 32'd0);
        check("reset a_mux_i", 32'(a_mux_i), 32'd0);
        check("reset b_sel_valid", 32'(b_sv), 32'd0);
        check("reset b_busy", 32'(b_busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // no load offered: everything stays idle
        repeat (10) @(negedge clk);
        check("idle a_mux_s", 32'(a_mux_s), 32'd0);
        check("idle a_mux_i", 32'(a_mux_i), 32'd0);
        check("idle a_ready", 32'(a_rdy), 32'd1);
        check("idle b_sel_valid", 32'(b_sv), 32'd0);

        // HOLD=1 LSB-first walk of 8'h05
        offer_once(8'h05);
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            y[i] = a_mux_i[a_mux_s];
            check("walk a_mux_s", 32'(a_mux_s), 32'(i));
            check("walk a_sel_last", 32'(a_sl), (i == 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("walk y bits", 32'(y), 32'h05);
        check("walk end busy", 32'(a_busy), 32'd0);
        check("walk end mux_s kept", 32'(a_mux_s), 32'd7);
        wait_idle();

        // HOLD=3 MSB-first word 8'hA5 on dut_b
        offer_once(8'hA5);
        sv_cnt = 0;
        sl_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0)  check("msb first sel", 32'(b_mux_s), 32'd7);
            if (i == 21) check("msb final sel", 32'(b_mux_s), 32'd0);
            sv_cnt += int'(b_sv);
            sl_cnt += int'(b_sl);
        end
        check("msb sel_valid clocks", 32'(sv_cnt), 32'd24);
        check("msb sel_last clocks", 32'(sl_cnt), 32'd3);
        check("msb mux_i", 32'(b_mux_i), 32'hA5);
        wait_idle();

        // back-to-back 8'h0F then 8'hF0 on dut_a
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data  = 8'h0F;
        @(posedge clk); #1;
        load_data  = 8'hF0;
        sv_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sv_cnt += int'(a_sv);
            if (i == 3) check("b2b ready mid", 32'(a_rdy), 32'd0);
            if (i == 7) begin
                check("b2b ready last", 32'(a_rdy), 32'd1);
                check("b2b old word", 32'(a_mux_i), 32'h0F);
            end
            if (i == 8) begin
                check("b2b new word", 32'(a_mux_i), 32'hF0);
                check("b2b restart sel", 32'(a_mux_s), 32'd0);
                load_valid = 1'b0;
            end
        end
        check("b2b contiguous beats", 32'(sv_cnt), 32'd16);
        wait_idle();

        // abort at mux_s=3 with a competing load of 8'h3C
        offer_once(8'h11);
        wait_sel_a(3'd3, found);
        check("abort reached sel 3", 32'(found), 32'd1);
        abort      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h3C;
        @(negedge clk);
        check("abort sel_valid", 32'(a_sv), 32'd0);
        check("abort busy", 32'(a_busy), 32'd0);
        check("abort mux_s", 32'(a_mux_s), 32'd0);
        check("abort mux_i kept", 32'(a_mux_i), 32'h11);
        abort = 1'b0;
        @(negedge clk);
        check("post-abort accept", 32'(a_mux_i), 32'h3C);
        check("post-abort sel_valid", 32'(a_sv), 32'd1);
        load_valid = 1'b0;
        wait_idle();

        // asynchronous reset at mux_s=5
        offer_once(8'h77);
        wait_sel_a(3'd5, found);
        check("reset reached sel 5", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst mux_s", 32'(a_mux_s), 32'd0);
        check("async rst mux_i", 32'(a_mux_i), 32'd0);
        check("async rst sel_valid", 32'(a_sv), 32'd0);
        check("async rst busy b", 32'(b_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after rst ready", 32'(a_rdy), 32'd1);
        offer_once(8'h81);
        @(negedge clk);
        check("after rst first sel", 32'(a_mux_s), 32'd0);
        check("after rst word", 32'(a_mux_i), 32'h81);
        wait_idle();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            load_valid = ($urandom_range(0, 9) < 6);
            load_data  = 8'($urandom);
            abort      = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        abort      = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
